// File: rtl/aoi221_test_sequencer.sv
// Exhaustive functional tester for one AOI221_X4 cell: sweeps all 32 input
// vectors, samples ZN after a settle time and checks it against a golden model.
module aoi221_test_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter bit          STOP_ON_FAIL  = 1'b0
) (
  input  logic       CK,
  input  logic       RST,
  input  logic       START,
  input  logic       ABORT,
  input  logic       ZN_IN,
  output logic       A,
  output logic       B1,
  output logic       B2,
  output logic       C1,
  output logic       C2,
  output logic       BUSY,
  output logic       DONE,
  output logic       PASS,
  output logic [5:0] ERR_CNT,
  output logic [4:0] FAIL_VEC
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_SAMPLE,
    S_DONE
  } state_t;

  state_t     state_q, state_d;
  logic [4:0] vec_q, vec_d;
  logic [3:0] cnt_q, cnt_d;
  logic [5:0] err_q, err_d;
  logic [4:0] fvec_q, fvec_d;

  logic golden;
  logic mismatch;
  logic settle_end;
  logic finish;

  assign golden     = ~(vec_q[4] | (vec_q[3] & vec_q[2]) | (vec_q[1] & vec_q[0]));
  assign mismatch   = (ZN_IN != golden);
  assign settle_end = (cnt_q == 4'(SETTLE_CYCLES - 1));
  assign finish     = (vec_q == 5'd31) || (STOP_ON_FAIL && mismatch);

  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (ABORT) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: if (START) state_d = S_SETTLE;
        S_SETTLE:       if (settle_end) state_d = S_SAMPLE;
        S_SAMPLE:       state_d = finish ? S_DONE : S_SETTLE;
        default:        state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    vec_d  = vec_q;
    cnt_d  = cnt_q;
    err_d  = err_q;
    fvec_d = fvec_q;
    if (ABORT) begin
      vec_d  = '0;
      cnt_d  = '0;
      err_d  = '0;
      fvec_d = '0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (START) begin
            vec_d  = '0;
            cnt_d  = '0;
            err_d  = '0;
            fvec_d = '0;
          end
        end
        S_SETTLE: cnt_d = cnt_q + 4'd1;
        S_SAMPLE: begin
          if (mismatch) begin
            if (err_q != 6'd32) err_d = err_q + 6'd1;
            if (err_q == 6'd0)  fvec_d = vec_q;
          end
          // On finish the vector is left in place so the pins hold the last pattern.
          if (!finish) begin
            vec_d = vec_q + 5'd1;
            cnt_d = '0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      vec_q  <= '0;
      cnt_q  <= '0;
      err_q  <= '0;
      fvec_q <= '0;
    end else begin
      vec_q  <= vec_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
      fvec_q <= fvec_d;
    end
  end

  always_comb begin
    BUSY = (state_q == S_SETTLE) || (state_q == S_SAMPLE);
    DONE = (state_q == S_DONE);
    PASS = (state_q == S_DONE) && (err_q == 6'd0);
  end

  assign A        = vec_q[4];
  assign B1       = vec_q[3];
  assign B2       = vec_q[2];
  assign C1       = vec_q[1];
  assign C2       = vec_q[0];
  assign ERR_CNT  = err_q;
  assign FAIL_VEC = fvec_q;

endmodule

// File: tb/tb_aoi221_test_sequencer.sv
// Directed bench for aoi221_test_sequencer with a behavioural CUT whose
// ZN can be correct, stuck-at-0, stuck-at-1 or inverted.
module tb_aoi221_test_sequencer;

  logic       CK = 1'b0;
  logic       RST = 1'b1;
  logic       START = 1'b0;
  logic       START2 = 1'b0;
  logic       ABORT = 1'b0;
  logic       ZN, ZN2;
  logic       A, B1, B2, C1, C2, BUSY, DONE, PASS;
  logic [5:0] ERR_CNT;
  logic [4:0] FAIL_VEC;
  logic       A2, B12, B22, C12, C22, BUSY2, DONE2, PASS2;
  logic [5:0] ERR_CNT2;
  logic [4:0] FAIL_VEC2;
  logic [4:0] pins, pins2;

  int checks = 0;
  int failures = 0;
  int mode = 0; // 0 good, 1 stuck0, 2 stuck1, 3 inverted

  always #5 CK = ~CK;

  function automatic logic cut_zn(input logic [4:0] v);
    return ~(v[4] | (v[3] & v[2]) | (v[1] & v[0]));
  endfunction

  assign pins  = {A, B1, B2, C1, C2};
  assign pins2 = {A2, B12, B22, C12, C22};

  always_comb begin
    case (mode)
      0:       ZN = cut_zn(pins);
      1:       ZN = 1'b0;
      2:       ZN = 1'b1;
      default: ZN = ~cut_zn(pins);
    endcase
  end
  assign ZN2 = ~cut_zn(pins2);

  aoi221_test_sequencer #(.SETTLE_CYCLES(2), .STOP_ON_FAIL(1'b0)) dut (
    .CK(CK), .RST(RST), .START(START), .ABORT(ABORT), .ZN_IN(ZN),
    .A(A), .B1(B1), .B2(B2), .C1(C1), .C2(C2),
    .BUSY(BUSY), .DONE(DONE), .PASS(PASS), .ERR_CNT(ERR_CNT), .FAIL_VEC(FAIL_VEC)
  );

  aoi221_test_sequencer #(.SETTLE_CYCLES(2), .STOP_ON_FAIL(1'b1)) dut_sof (
    .CK(CK), .RST(RST), .START(START2), .ABORT(ABORT), .ZN_IN(ZN2),
    .A(A2), .B1(B12), .B2(B22), .C1(C12), .C2(C22),
    .BUSY(BUSY2), .DONE(DONE2), .PASS(PASS2), .ERR_CNT(ERR_CNT2), .FAIL_VEC(FAIL_VEC2)
  );

  // Leaves the bench at the falling edge right after the edge that sampled START.
  task automatic pulse_start();
    @(negedge CK) START = 1'b1;
    @(posedge CK);
    @(negedge CK) START = 1'b0;
  endtask

  task automatic wait_done(input int maxc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      @(negedge CK);
      if (DONE) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge CK);
    checks++;
    if ({pins, BUSY, DONE, PASS, ERR_CNT, FAIL_VEC} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got pins=%b busy=%b done=%b pass=%b err=%0d fvec=%b, want all 0",
               pins, BUSY, DONE, PASS, ERR_CNT, FAIL_VEC);
    end
    RST = 1'b0;
    @(negedge CK);
    checks++;
    if (BUSY !== 1'b0 || DONE !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle: got busy=%b done=%b, want 0 0", BUSY, DONE);
    end
  endtask

  task automatic test_full_sweep();
    logic [4:0] exp;
    mode = 0;
    pulse_start();
    checks++;
    if (pins !== 5'd0 || BUSY !== 1'b1) begin
      failures++;
      $display("FAIL full_start: got pins=%0d busy=%b, want 0 1", pins, BUSY);
    end
    for (int j = 1; j <= 96; j++) begin
      @(negedge CK);
      exp = (j < 96) ? 5'(j / 3) : 5'd31;
      checks++;
      if (pins !== exp || DONE !== (j == 96)) begin
        failures++;
        $display("FAIL full_step%0d: got pins=%0d done=%b, want pins=%0d done=%b", j, pins, DONE, exp, j == 96);
      end
    end
    checks++;
    if (PASS !== 1'b1 || BUSY !== 1'b0 || ERR_CNT !== 6'd0 || FAIL_VEC !== 5'd0) begin
      failures++;
      $display("FAIL full_result: got pass=%b busy=%b err=%0d fvec=%b, want 1 0 0 00000",
               PASS, BUSY, ERR_CNT, FAIL_VEC);
    end
  endtask

  task automatic test_stuck0();
    bit ok;
    mode = 1;
    pulse_start();
    wait_done(200, ok);
    checks++;
    if (!ok || ERR_CNT !== 6'd9 || FAIL_VEC !== 5'b00000 || PASS !== 1'b0) begin
      failures++;
      $display("FAIL stuck0: got done=%b err=%0d fvec=%b pass=%b, want 1 9 00000 0", ok, ERR_CNT, FAIL_VEC, PASS);
    end
  endtask

  task automatic test_stuck1();
    bit ok;
    mode = 2;
    pulse_start();
    wait_done(200, ok);
    checks++;
    if (!ok || ERR_CNT !== 6'd23 || FAIL_VEC !== 5'b00011 || PASS !== 1'b0) begin
      failures++;
      $display("FAIL stuck1: got done=%b err=%0d fvec=%b pass=%b, want 1 23 00011 0", ok, ERR_CNT, FAIL_VEC, PASS);
    end
    checks++;
    if (pins !== 5'd31) begin
      failures++;
      $display("FAIL stuck1_hold: got pins=%0d, want 31", pins);
    end
  endtask

  task automatic test_stop_on_fail();
    @(negedge CK) START2 = 1'b1;
    @(posedge CK);
    @(negedge CK) START2 = 1'b0;
    repeat (2) @(negedge CK);
    checks++;
    if (DONE2 !== 1'b0 || BUSY2 !== 1'b1) begin
      failures++;
      $display("FAIL sof_early: got done=%b busy=%b, want 0 1", DONE2, BUSY2);
    end
    @(negedge CK);
    checks++;
    if (DONE2 !== 1'b1 || ERR_CNT2 !== 6'd1 || FAIL_VEC2 !== 5'd0 || pins2 !== 5'd0 || PASS2 !== 1'b0) begin
      failures++;
      $display("FAIL sof_done: got done=%b err=%0d fvec=%b pins=%0d pass=%b, want 1 1 0 0 0",
               DONE2, ERR_CNT2, FAIL_VEC2, pins2, PASS2);
    end
  endtask

  task automatic test_abort();
    bit ok;
    mode = 1;
    pulse_start();
    repeat (36) @(negedge CK);
    checks++;
    if (pins !== 5'd12 || ERR_CNT === 6'd0) begin
      failures++;
      $display("FAIL abort_pre: got pins=%0d err=%0d, want pins=12 err nonzero", pins, ERR_CNT);
    end
    ABORT = 1'b1;
    @(negedge CK) ABORT = 1'b0;
    checks++;
    if ({pins, BUSY, DONE, PASS, ERR_CNT, FAIL_VEC} !== '0) begin
      failures++;
      $display("FAIL abort_clear: got pins=%0d busy=%b done=%b pass=%b err=%0d fvec=%b, want all 0",
               pins, BUSY, DONE, PASS, ERR_CNT, FAIL_VEC);
    end
    @(negedge CK);
    checks++;
    if (BUSY !== 1'b0 || pins !== 5'd0) begin
      failures++;
      $display("FAIL abort_idle: got busy=%b pins=%0d, want 0 0", BUSY, pins);
    end
    mode = 0;
    pulse_start();
    wait_done(200, ok);
    checks++;
    if (!ok || PASS !== 1'b1 || ERR_CNT !== 6'd0) begin
      failures++;
      $display("FAIL abort_rerun: got done=%b pass=%b err=%0d, want 1 1 0", ok, PASS, ERR_CNT);
    end
  endtask

  task automatic test_start_while_busy();
    logic [4:0] exp;
    mode = 0;
    pulse_start();
    for (int j = 1; j <= 96; j++) begin
      @(negedge CK);
      START = (j == 50);
      exp = (j < 96) ? 5'(j / 3) : 5'd31;
      checks++;
      if (pins !== exp || DONE !== (j == 96)) begin
        failures++;
        $display("FAIL busy_start_step%0d: got pins=%0d done=%b, want pins=%0d done=%b", j, pins, DONE, exp, j == 96);
      end
    end
    checks++;
    if (PASS !== 1'b1) begin
      failures++;
      $display("FAIL busy_start_pass: got %b, want 1", PASS);
    end
  endtask

  task automatic test_async_reset();
    mode = 1;
    pulse_start();
    repeat (20) @(negedge CK);
    checks++;
    if (ERR_CNT !== 6'd5 || pins !== 5'd6) begin
      failures++;
      $display("FAIL areset_pre: got err=%0d pins=%0d, want 5 6", ERR_CNT, pins);
    end
    @(posedge CK);
    #2 RST = 1'b1;
    #1;
    checks++;
    if ({pins, BUSY, DONE, PASS, ERR_CNT, FAIL_VEC} !== '0) begin
      failures++;
      $display("FAIL areset_async: got pins=%0d busy=%b done=%b pass=%b err=%0d fvec=%b, want all 0",
               pins, BUSY, DONE, PASS, ERR_CNT, FAIL_VEC);
    end
    @(negedge CK) RST = 1'b0;
    @(negedge CK);
    checks++;
    if (BUSY !== 1'b0 || pins !== 5'd0) begin
      failures++;
      $display("FAIL areset_idle: got busy=%b pins=%0d, want 0 0", BUSY, pins);
    end
  endtask

  task automatic test_start_abort_done();
    bit ok;
    mode = 0;
    pulse_start();
    wait_done(200, ok);
    checks++;
    if (!ok || PASS !== 1'b1) begin
      failures++;
      $display("FAIL sa_reach_done: got done=%b pass=%b, want 1 1", ok, PASS);
    end
    START = 1'b1;
    ABORT = 1'b1;
    @(negedge CK);
    START = 1'b0;
    ABORT = 1'b0;
    checks++;
    if (DONE !== 1'b0 || BUSY !== 1'b0 || PASS !== 1'b0 || pins !== 5'd0) begin
      failures++;
      $display("FAIL sa_priority: got done=%b busy=%b pass=%b pins=%0d, want 0 0 0 0", DONE, BUSY, PASS, pins);
    end
    repeat (3) @(negedge CK);
    checks++;
    if (BUSY !== 1'b0 || DONE !== 1'b0) begin
      failures++;
      $display("FAIL sa_stays_idle: got busy=%b done=%b, want 0 0", BUSY, DONE);
    end
  endtask

  initial begin
    test_reset();
    test_full_sweep();
    test_stuck0();
    test_stuck1();
    test_stop_on_fail();
    test_abort();
    test_start_while_busy();
    test_async_reset();
    test_start_abort_done();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
